// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO behind a UART receiver with sticky overrun flag
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    input  logic              clr_overrun,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              done_q;

    logic              push;
    logic              pop;
    logic              wr_accept;
    logic              overrun_set;
    logic [ADDR_W:0]   count_next;

    // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
    always_comb begin
        push        = rx_done & ~done_q;
        pop         = rd_en & ~empty;
        wr_accept   = push & (~full | pop);
        overrun_set = push & full & ~pop;
        count_next  = count;
        if (wr_accept && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !wr_accept) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage is not reset; the read of the old entry and the write of the
    // freed slot can share an index because rd_data takes the pre-edge value.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
            empty    <= 1'b1;
            full     <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            done_q   <= rx_done;
            rd_valid <= pop;
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == FULL_CNT);
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed vector bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       clr_overrun;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_count;
        logic       e_empty;
        logic       e_full;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input logic [7:0] exp, input string name);
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk({name, " rd_valid"}, 32'(rd_valid), 32'd1);
        chk({name, " rd_data"}, 32'(rd_data), 32'(exp));
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        // done data rd clr | valid data count empty full ovr
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rx_done     = vecs[i].done;
            rx_data     = vecs[i].data;
            rd_en       = vecs[i].rd;
            clr_overrun = vecs[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d rd_data", i),  32'(rd_data),  32'(vecs[i].e_data));
            chk($sformatf("vec%0d count", i),    32'(count),    32'(vecs[i].e_count));
            chk($sformatf("vec%0d empty", i),    32'(empty),    32'(vecs[i].e_empty));
            chk($sformatf("vec%0d full", i),     32'(full),     32'(vecs[i].e_full));
            chk($sformatf("vec%0d overrun", i),  32'(overrun),  32'(vecs[i].e_ovr));
        end
        @(negedge clk);
        rx_done = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;

        // Fill, overflow, drain, then clear the sticky flag
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill full", 32'(full), 32'd1);
        chk("fill count", 32'(count), 32'd16);
        chk("fill overrun", 32'(overrun), 32'd0);
        push(8'h10);
        chk("ovf overrun", 32'(overrun), 32'd1);
        chk("ovf count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) pop(8'(i), $sformatf("drain%0d", i));
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain overrun sticky", 32'(overrun), 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        chk("clr overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        clr_overrun = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        @(negedge clk);
        rx_done = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("fullrw rd_valid", 32'(rd_valid), 32'd1);
        chk("fullrw rd_data", 32'(rd_data), 32'h20);
        chk("fullrw count", 32'(count), 32'd16);
        chk("fullrw full", 32'(full), 32'd1);
        chk("fullrw overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rx_done = 1'b0; rd_en = 1'b0;
        for (int i = 1; i < 16; i++) pop(8'(8'h20 + i), $sformatf("fullrw_drain%0d", i));
        pop(8'h55, "fullrw last");
        chk("fullrw empty", 32'(empty), 32'd1);

        // Pointer wrap with interleaved traffic
        push(8'h80);
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h81 + i));
            chk($sformatf("wrap%0d count", i), 32'(count <= 5'd2), 32'd1);
            pop(8'(8'h80 + i), $sformatf("wrap%0d", i));
        end
        pop(8'(8'h80 + 40), "wrap tail");
        chk("wrap empty", 32'(empty), 32'd1);
        chk("wrap overrun", 32'(overrun), 32'd0);

        // Empty FIFO: simultaneous rd_en and push
        @(negedge clk);
        rx_done = 1'b1; rx_data = 8'h81; rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("emptyrw rd_valid", 32'(rd_valid), 32'd0);
        chk("emptyrw count", 32'(count), 32'd1);
        @(negedge clk);
        rx_done = 1'b0;
        @(posedge clk);
        #1;
        chk("emptyrw next rd_valid", 32'(rd_valid), 32'd1);
        chk("emptyrw next rd_data", 32'(rd_data), 32'h81);
        @(negedge clk);
        rd_en = 1'b0;

        // Reset mid-stream with rx_done held across it
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        chk("pre-rst count", 32'(count), 32'd5);
        @(negedge clk);
        rst = 1'b1; rx_done = 1'b1; rx_data = 8'hEE;
        @(posedge clk);
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst overrun", 32'(overrun), 32'd0);
        chk("rst rd_valid", 32'(rd_valid), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post-rst held done", 32'(count), 32'd0);
        @(negedge clk);
        rx_done = 1'b0;
        push(8'h3A);
        chk("post-rst push count", 32'(count), 32'd1);
        pop(8'h3A, "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver; consumes the receiver's done strobe and 8-bit data output.
- Captures one byte per rising edge of rx_done into a circular FIFO.
- Presents bytes to the consuming logic through a registered read port.
- Flags dropped bytes with a sticky overrun bit so bursts on rx survive slow consumers.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
rx_done  input  1  receiver done flag; may stay high more than one cycle
rx_data  input  8  receiver data output; valid when rx_done rises
rd_en  input  1  read request from the consumer
clr_overrun  input  1  clears the sticky overrun flag
rd_data  output  8  byte popped by the last accepted read
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds DEPTH bytes
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Synchronous, active-high reset; all state clears on the clk edge where rst=1:
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overrun=0.
  - empty=1, full=0.
  - Edge-detect register done_q=1, so an rx_done level held across reset is not counted as a byte.
  - Storage array contents are don't-care.
- Push event: push = rx_done & ~done_q; done_q <= rx_done every cycle.
  - Exactly one push per rising edge, regardless of how long rx_done stays high.
  - rx_data is sampled in the same cycle as the push.
- Pop event: pop = rd_en & ~empty, using the registered empty.
  - rd_en while empty is ignored: no pointer change, no rd_valid, rd_data holds.
- Read latency: one cycle. On a pop, mem[rd_ptr] is registered into rd_data and rd_valid=1 on the next edge. rd_data holds its value until the next pop.
- Write:
  - When accepted, mem[wr_ptr] <= rx_data.
  - Pointers increment modulo DEPTH; natural ADDR_W-bit wrap, no special case.
- count, empty and full are registered. count changes as follows:
  - push only: +1
  - pop only: -1
  - both: unchanged
- Boundary cases:
  - Full, push only: byte dropped; count, wr_ptr and storage unchanged; overrun <= 1.
  - Full, push and pop in the same cycle: both accepted, count stays DEPTH, no overrun. The pop reads the oldest entry; the write goes to the freed slot, which is the same index and is legal because the read takes the old data.
  - Empty, push and pop in the same cycle: pop ignored (empty=1); push accepted; count=1. The byte is readable no earlier than the following cycle, so there is no write-through.
  - Count reaches DEPTH: full=1 on the same edge that count becomes DEPTH. empty=1 on the edge count becomes 0.
  - clr_overrun together with a new overrun event: set wins, overrun stays 1.
  - clr_overrun otherwise: overrun <= 0 next edge.
  - Reset mid-operation: all stored bytes are discarded; the first post-reset push requires a fresh rising edge of rx_done.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset, then one rx_done pulse with rx_data=8'hA5 -> count=1, empty=0. Then rd_en for 1 cycle -> next cycle rd_valid=1, rd_data=8'hA5, count=0, empty=1.
2. rx_done held high for 5 cycles with rx_data=8'h3C -> exactly one byte stored, count=1.
3. DEPTH=16: push 0x00..0x0F -> full=1, count=16. Push 0x10 -> overrun=1, count=16. Drain all 16 -> reads 0x00..0x0F in order, empty=1. overrun stays 1 until clr_overrun=1.
4. FIFO full, push 0x55 and pop in the same cycle -> rd_data = oldest byte, count stays 16, overrun=0. The 0x55 is read last after a full drain.
5. Pointer wrap: 40 interleaved push/pop pairs with an incrementing data pattern -> every byte is read back in order, count never exceeds 2, no overrun.
6. Empty FIFO, rd_en=1 with a simultaneous push 0x81 -> no rd_valid that cycle, count=1. rd_en next cycle -> rd_data=0x81. Assert rst mid-stream with 5 bytes queued -> count=0, empty=1, overrun=0, rd_valid=0.
